// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor. WIDTH bits are split into STAGES ripple
// slices with a register after each; carry, unprocessed operand bits and finished sum bits travel with the beat.
module pipelined_rca_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;

  // valid/ready: a beat transfers on any rising edge where valid & ready are both high.
  // The whole pipe moves as one; it freezes only when the output holds an unaccepted result.
  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SLICE;
    localparam int HI  = (k + 1) * SLICE;
    localparam int RIN = WIDTH - LO;

    logic [RIN-1:0] a_src;
    logic [RIN-1:0] b_src;
    logic           c_src;
    logic           v_src;
    logic [SLICE:0] slice_sum;
    logic [HI-1:0]  s_d;
    logic [HI-1:0]  s_q;
    logic           c_d;
    logic           c_q;
    logic           v_q;

    if (k == 0) begin : g_in
      assign a_src = a;
      assign b_src = b_eff;
      assign c_src = sub | cin;
      assign v_src = in_valid;
      assign s_d   = slice_sum[SLICE-1:0];
    end else begin : g_in
      assign a_src = g_stage[k-1].g_skew.a_q;
      assign b_src = g_stage[k-1].g_skew.b_q;
      assign c_src = g_stage[k-1].c_q;
      assign v_src = g_stage[k-1].v_q;
      assign s_d   = {slice_sum[SLICE-1:0], g_stage[k-1].s_q};
    end

    assign slice_sum = {1'b0, a_src[SLICE-1:0]} + {1'b0, b_src[SLICE-1:0]}
                     + {{SLICE{1'b0}}, c_src};
    assign c_d       = slice_sum[SLICE];

    // Data registers load only for real beats, so the output holds its last result across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_src;
        if (v_src) begin
          c_q <= c_d;
          s_q <= s_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [RIN-SLICE-1:0] a_q;
      logic [RIN-SLICE-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_src) begin
          a_q <= a_src[RIN-1:SLICE];
          b_q <= b_src[RIN-1:SLICE];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance && v_src) begin
          ovf_q <= (a_src[RIN-1] == b_src[RIN-1]) & (slice_sum[SLICE-1] != a_src[RIN-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder (WIDTH=64, STAGES=4): directed vector table,
// latency/burst/stall/async-reset sequences and a random valid/ready run against a reference model.
module tb_pipelined_rca_adder;
  localparam int W  = 64;
  localparam int S  = 4;
  localparam int NV = 11;
  localparam int N_RAND = 1500;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] cur_exp;
  logic         last_acc;
  int           checks;
  int           errors;
  vec_t         vecs [NV];

  pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                              input logic cin_v, input logic sub_v);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = sub_v ? ~b_v : b_v;
    full = {1'b0, a_v} + {1'b0, bb} + {{W{1'b0}}, (sub_v ? 1'b1 : cin_v)};
    ov   = (a_v[W-1] == bb[W-1]) && (full[W-1] != a_v[W-1]);
    return {full[W-1:0], full[W], ov};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst) begin
      last_acc = 1'b0;
    end else begin
      last_acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got sum=%h cout=%b ovf=%b, expected no result", sum, cout, ovf);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e[W+1:2], e[1], e[0]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                            input logic cin_v, input logic sub_v, input logic [W+1:0] exp_v);
    a        = a_v;
    b        = b_v;
    cin      = cin_v;
    sub      = sub_v;
    cur_exp  = exp_v;
    in_valid = 1'b1;
  endtask

  task automatic check_val(input string name, input logic [W+1:0] got, input logic [W+1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats pending after %0d cycles, expected 0", exp_q.size(), max_cyc);
    end
    check_val("no_extra_out", {{(W+1){1'b0}}, out_valid}, '0);
  endtask

  task automatic latency_check(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                               input logic cin_v, input logic sub_v, input logic [W+1:0] exp_v);
    int n;
    drive_beat(a_v, b_v, cin_v, sub_v, exp_v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != S) begin
      errors++;
      $display("FAIL %s: out_valid after %0d edges, expected %0d", name, n, S);
    end
    wait_drain(10);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W+1:0] e0;
    int first_c, last_c, cnt, acc, cyc;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[4]  = '{64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7]  = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{64'h0, 64'h0, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[9]  = '{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[10] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                 64'h2222_2222_2222_2211, 1'b0, 1'b0};

    checks = 0; errors = 0; last_acc = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; cur_exp = '0;

    // Reset state
    #3;
    check_val("reset_out_valid", {{(W+1){1'b0}}, out_valid}, '0);
    check_val("reset_in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
    check_val("reset_result", {sum, cout, ovf}, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Full cross-slice carry plus latency
    latency_check("latency_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, {64'h0, 1'b1, 1'b0});

    // Directed vector table, back-to-back
    for (int i = 0; i < NV; i++) begin
      drive_beat(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, {vecs[i].sum, vecs[i].cout, vecs[i].ovf});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain(20);

    // Burst of 8 beats: results must appear on 8 consecutive cycles
    first_c = -1; last_c = -1; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        drive_beat(W'(c), W'(c) << 60, 1'b0, 1'b0, ref_result(W'(c), W'(c) << 60, 1'b0, 1'b0));
        check_val("burst_in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        cnt++;
      end
    end
    check_val("burst_count", W'(cnt), W'(8));
    check_val("burst_contiguous", W'(last_c - first_c), W'(7));
    wait_drain(10);

    // Stall: 4 beats in flight, out_ready low for 6 cycles, a 5th beat offered meanwhile
    out_ready = 1'b0;
    e0 = ref_result(64'h100, 64'h0000_0001_0000_0000, 1'b1, 1'b0);
    drive_beat(64'h100, 64'h0000_0001_0000_0000, 1'b1, 1'b0, e0);
    @(posedge clk); #1;
    drive_beat(64'h200, 64'h50, 1'b0, 1'b1, ref_result(64'h200, 64'h50, 1'b0, 1'b1));
    @(posedge clk); #1;
    drive_beat(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0, 1'b0,
               ref_result(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0, 1'b0));
    @(posedge clk); #1;
    drive_beat(64'h3, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
               ref_result(64'h3, 64'h8000_0000_0000_0000, 1'b0, 1'b1));
    @(posedge clk); #1;
    drive_beat(64'h9, 64'h9, 1'b1, 1'b0, ref_result(64'h9, 64'h9, 1'b1, 1'b0));
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      check_val("stall_ctrl", {{W{1'b0}}, out_valid, in_ready}, {{W{1'b0}}, 2'b10});
      check_val("stall_hold", {sum, cout, ovf}, e0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(20);

    // Asynchronous reset with 3 beats in flight, first one at the output
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive_beat(W'(j + 40), W'(j + 1), 1'b0, 1'b0, ref_result(W'(j + 40), W'(j + 1), 1'b0, 1'b0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("pre_reset_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_val("async_reset_valid", {{(W+1){1'b0}}, out_valid}, '0);
    check_val("async_reset_result", {sum, cout, ovf}, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check_val("no_stale_beat", {{(W+1){1'b0}}, out_valid}, '0);
    end
    latency_check("latency_after_reset", 64'h8000_0000_0000_0001, 64'h1, 1'b0, 1'b1,
                  {64'h8000_0000_0000_0000, 1'b1, 1'b0});

    // Random operands with random valid/ready; a beat is held until accepted
    acc = 0; cyc = 0;
    while (cyc < 10000) begin
      if (last_acc) acc++;
      if (acc >= N_RAND) break;
      if (!in_valid || last_acc) begin
        if ($urandom_range(0, 3) != 0) begin
          ra = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
          rb = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          drive_beat(ra, rb, rc, rs, ref_result(ra, rb, rc, rs));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_val("random_beats_accepted", W'(acc), W'(N_RAND));
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
